// File: rtl/sync_down_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sync_down_counter
//  Brief    : Loadable down counter with periodic/one-shot modes, registered
//             terminal-count pulse and a two-state IDLE/RUN controller.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             zero_o,
    output logic             busy_o
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_RUN  = 1'b1;
    localparam logic [WIDTH-1:0] c_ZERO    = '0;
    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    logic w_count_zero;
    logic w_count_one;
    logic w_step;

    assign w_count_zero = (r_count == c_ZERO);
    assign w_count_one  = (r_count == c_ONE);
    assign w_step       = (r_state == c_ST_RUN) && en_i;

    // Load wins over everything; otherwise only an enabled RUN cycle moves state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= c_ST_IDLE;
            r_count  <= c_ZERO;
            r_reload <= '1;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load_i) begin
                r_count  <= load_val_i;
                r_reload <= load_val_i;
                r_state  <= (load_val_i != c_ZERO) ? c_ST_RUN : c_ST_IDLE;
            end else if (w_step) begin
                if (!w_count_zero) begin
                    r_count <= r_count - c_ONE;
                    if (w_count_one) begin
                        r_tc <= 1'b1;
                        if (mode_i) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end else if (mode_i) begin
                    // One-shot selected while parked at zero: stop, no pulse.
                    r_state <= c_ST_IDLE;
                end else begin
                    r_count <= r_reload;
                end
            end
        end
    end

    assign count_o = r_count;
    assign tc_o    = r_tc;
    assign zero_o  = w_count_zero;
    assign busy_o  = (r_state == c_ST_RUN);

endmodule
`default_nettype wire
